ex_muldiv_unit: RTL and testbench
=================================

// Module: ex_muldiv_unit
// PURPOSE
//  EX-stage consumer of the ID/EX pipeline register outputs: executes MULT/MULTU/DIV/DIVU
//  iteratively (1 bit/cycle), owns the HI/LO registers, services MTHI/MTLO/MFHI/MFLO.
//  While an operation runs it asserts stall, which freezes PC, IF/ID and ID/EX so the
//  mul/div instruction stays in EX until its result is written.
// PARAMETERS
//  WIDTH  32  operand width; iteration count = WIDTH (only 32 is verified)
// PORTS
//  clk        in   1      single clock, rising edge
//  reset      in   1      asynchronous, active-high
//  opcode     in   6      ID/EX opcode; only 6'h00 (R-type) decodes here
//  funct      in   6      ID/EX funct
//  rs_data    in   WIDTH  ID/EX rs operand (dividend / multiplicand / MTxx source)
//  rt_data    in   WIDTH  ID/EX rt operand (divisor / multiplier)
//  stall      out  1      hold PC, IF/ID, ID/EX this cycle
//  busy       out  1      FSM not in IDLE
//  hi         out  WIDTH  HI register
//  lo         out  WIDTH  LO register
//  mf_result  out  WIDTH  hi for MFHI, lo for MFLO, else 0 (combinational)
//  mf_valid   out  1      MFHI/MFLO currently in EX
//  div_zero   out  1      1-cycle pulse: DIV/DIVU with rt_data==0 completed
// BEHAVIOUR
//  Decode (opcode==0): MFHI 10h, MTHI 11h, MFLO 12h, MTLO 13h, MULT 18h, MULTU 19h,
//   DIV 1Ah, DIVU 1Bh. Anything else: no effect.
//  Reset: state=IDLE, hi=lo=0, counter=0, all datapath regs 0; stall=busy=div_zero=0.
//   Reset mid-operation aborts it; HI/LO read 0 afterwards.
//  States: IDLE, MUL, DIV, FIXUP.
//  IDLE + mul/div op in EX: stall=1; latch |rs|,|rt| (signed ops) or raw (unsigned), latch
//   result sign, counter=0 -> MUL or DIV. DIV/DIVU with rt_data==0 -> FIXUP directly.
//  MUL: shift-add, one multiplier bit per cycle, 2*WIDTH accumulator; stall=1; after
//   WIDTH cycles (counter==WIDTH-1) -> FIXUP.
//  DIV: restoring, one quotient bit per cycle; stall=1; after WIDTH cycles -> FIXUP.
//  FIXUP: stall=0; HI/LO written at end of cycle; -> IDLE. Instruction leaves EX at the
//   same edge, so the mul/div op in EX during FIXUP is never re-accepted.
//  Latency: normal op occupies EX WIDTH+2 cycles (34): WIDTH+1 stalled + FIXUP.
//   Divide-by-zero: 2 cycles (1 stalled).
//  Sign rules: MULT product negated (2*WIDTH two's complement) iff operand signs differ.
//   DIV quotient negative iff signs differ; remainder takes dividend sign.
//   -2^31 / -1 -> LO=32'h8000_0000, HI=0. HI=remainder/product[63:32], LO=quotient/[31:0].
//  Divide-by-zero: HI=rs_data, LO=32'hFFFF_FFFF (signed and unsigned), div_zero=1 in FIXUP.
//  MTHI/MTLO in IDLE: hi/lo <= rs_data at end of cycle, no stall. Cannot reach EX while
//   busy (pipeline frozen). MFHI/MFLO: mf_result from current hi/lo; the cycle after
//   FIXUP sees the new value.
//  Operands are sampled only in IDLE; rs_data/rt_data changes while busy are ignored.
//  stall = (state==IDLE & muldiv_op) | state==MUL | state==DIV.
// STRUCTURE
//  Shared package mips_pkg: OPCODE_RTYPE, FUNCT_{MFHI,MTHI,MFLO,MTLO,MULT,MULTU,DIV,DIVU},
//   muldiv_state_t enum {IDLE,MUL,DIV,FIXUP}.
//  One sub-module: muldiv_core (counter, accumulator/remainder/quotient shift regs, one
//   step per enable). Decode, FSM, sign fixup, HI/LO and stall stay in this module.
// TESTING
//  MULTU 32'hFFFF_FFFF*32'hFFFF_FFFF -> stall 33 cycles; HI=FFFF_FFFE, LO=0000_0001.
//  MULT -3*7 -> HI=FFFF_FFFF, LO=FFFF_FFEB; then MFLO next cycle -> mf_result=FFFF_FFEB.
//  DIV -7/2 -> LO=FFFF_FFFD, HI=FFFF_FFFF; DIV 32'h8000_0000 / -1 -> LO=8000_0000, HI=0.
//  DIVU 100/0 -> stall 1 cycle, div_zero pulse, HI=100, LO=FFFF_FFFF.
//  MTHI 5 then MTLO 9 back-to-back -> no stall, hi=5, lo=9; MFHI -> mf_valid=1, 5.
//  Assert reset at cycle 10 of a DIVU -> stall/busy 0 immediately, hi=lo=0; next MULTU 3*4
//   -> LO=12, HI=0.

Source files
------------

// File: rtl/ex_muldiv_unit_pkg.sv
// Shared MIPS decode constants and the mul/div FSM state type.
package mips_pkg;

    localparam logic [5:0] OPCODE_RTYPE = 6'h00;
    localparam logic [5:0] FUNCT_MFHI   = 6'h10;
    localparam logic [5:0] FUNCT_MTHI   = 6'h11;
    localparam logic [5:0] FUNCT_MFLO   = 6'h12;
    localparam logic [5:0] FUNCT_MTLO   = 6'h13;
    localparam logic [5:0] FUNCT_MULT   = 6'h18;
    localparam logic [5:0] FUNCT_MULTU  = 6'h19;
    localparam logic [5:0] FUNCT_DIV    = 6'h1A;
    localparam logic [5:0] FUNCT_DIVU   = 6'h1B;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        MUL   = 2'd1,
        DIV   = 2'd2,
        FIXUP = 2'd3
    } muldiv_state_t;

endpackage

// File: rtl/ex_muldiv_unit_if.sv
// ID/EX-side bundle for the mul/div unit: decoded operands in, stall/HI/LO/MF results out.
interface ex_muldiv_unit_if #(
    parameter int WIDTH = 32
);
    logic [5:0]       opcode;
    logic [5:0]       funct;
    logic [WIDTH-1:0] rs_data;
    logic [WIDTH-1:0] rt_data;
    logic             stall;
    logic             busy;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;
    logic [WIDTH-1:0] mf_result;
    logic             mf_valid;
    logic             div_zero;

    modport master (
        output opcode, funct, rs_data, rt_data,
        input  stall, busy, hi, lo, mf_result, mf_valid, div_zero
    );

    modport slave (
        input  opcode, funct, rs_data, rt_data,
        output stall, busy, hi, lo, mf_result, mf_valid, div_zero
    );
endinterface

// File: rtl/ex_muldiv_unit_core.sv
// Iterative unsigned datapath: shift-add multiply or restoring divide, one bit per step.
// The 2*WIDTH register holds {accumulator, multiplier} for MUL and {remainder, quotient} for DIV.
module muldiv_core #(
    parameter int WIDTH = 32
) (
    input  logic               i_clk,
    input  logic               i_rst,
    input  logic               i_load,
    input  logic               i_step,
    input  logic               i_div,
    input  logic [WIDTH-1:0]   i_x,
    input  logic [WIDTH-1:0]   i_y,
    output logic               o_last,
    output logic [2*WIDTH-1:0] o_acc
);
    localparam int CW = $clog2(WIDTH);

    logic [2*WIDTH-1:0] r_acc;
    logic [WIDTH-1:0]   r_y;
    logic               r_div;
    logic [CW-1:0]      r_count;

    logic [WIDTH:0]     w_sum;
    logic [WIDTH:0]     w_trial;
    logic [WIDTH:0]     w_diff;
    logic [2*WIDTH-1:0] w_next;

    // One iteration of the selected algorithm
    always_comb begin
        w_sum   = {1'b0, r_acc[2*WIDTH-1:WIDTH]} + (r_acc[0] ? {1'b0, r_y} : '0);
        // Remainder stays below the divisor, so the shifted trial fits in WIDTH+1 bits
        w_trial = {r_acc[2*WIDTH-1:WIDTH], r_acc[WIDTH-1]};
        w_diff  = w_trial - {1'b0, r_y};
        if (r_div) begin
            if (w_diff[WIDTH])
                w_next = {w_trial[WIDTH-1:0], r_acc[WIDTH-2:0], 1'b0};
            else
                w_next = {w_diff[WIDTH-1:0], r_acc[WIDTH-2:0], 1'b1};
        end else begin
            w_next = {w_sum, r_acc[WIDTH-1:1]};
        end
    end

    // Operand load on accept, then one step per enabled cycle
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_acc   <= '0;
            r_y     <= '0;
            r_div   <= 1'b0;
            r_count <= '0;
        end else if (i_load) begin
            r_acc   <= {{WIDTH{1'b0}}, i_x};
            r_y     <= i_y;
            r_div   <= i_div;
            r_count <= '0;
        end else if (i_step) begin
            r_acc   <= w_next;
            r_count <= r_count + 1'b1;
        end
    end

    assign o_last = (r_count == CW'(WIDTH - 1));
    assign o_acc  = r_acc;
endmodule

// File: rtl/ex_muldiv_unit.sv
// EX-stage MULT/MULTU/DIV/DIVU sequencer with HI/LO registers and MTxx/MFxx service.
module ex_muldiv_unit
    import mips_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic              clk,
    input  logic              reset,
    ex_muldiv_unit_if.slave   ex
);
    muldiv_state_t      r_state;
    logic [WIDTH-1:0]   r_hi;
    logic [WIDTH-1:0]   r_lo;
    logic               r_neg_q;
    logic               r_neg_r;
    logic               r_is_div;
    logic               r_dz;

    logic               w_rtype, w_is_mul, w_is_div, w_signed, w_muldiv_op, w_rt_zero;
    logic               w_rs_neg, w_rt_neg, w_load, w_step, w_last;
    logic [WIDTH-1:0]   w_rs_abs, w_rt_abs, w_x, w_y, w_quot, w_rem;
    logic [2*WIDTH-1:0] w_acc, w_prod;

    // Decode and operand magnitude preparation
    always_comb begin
        w_rtype     = (ex.opcode == OPCODE_RTYPE);
        w_is_mul    = w_rtype && (ex.funct == FUNCT_MULT || ex.funct == FUNCT_MULTU);
        w_is_div    = w_rtype && (ex.funct == FUNCT_DIV  || ex.funct == FUNCT_DIVU);
        w_signed    = (ex.funct == FUNCT_MULT || ex.funct == FUNCT_DIV);
        w_muldiv_op = w_is_mul || w_is_div;
        w_rt_zero   = (ex.rt_data == '0);
        w_rs_neg    = w_signed && ex.rs_data[WIDTH-1];
        w_rt_neg    = w_signed && ex.rt_data[WIDTH-1];
        w_rs_abs    = w_rs_neg ? -ex.rs_data : ex.rs_data;
        w_rt_abs    = w_rt_neg ? -ex.rt_data : ex.rt_data;
        w_load      = (r_state == IDLE) && w_muldiv_op;
        w_step      = (r_state == MUL) || (r_state == DIV);
        // Divide-by-zero parks the raw dividend in the core so FIXUP can copy it to HI
        w_x         = w_is_mul ? w_rt_abs : (w_rt_zero ? ex.rs_data : w_rs_abs);
        w_y         = w_is_mul ? w_rs_abs : w_rt_abs;
    end

    muldiv_core #(.WIDTH(WIDTH)) u_core (
        .i_clk  (clk),
        .i_rst  (reset),
        .i_load (w_load),
        .i_step (w_step),
        .i_div  (w_is_div),
        .i_x    (w_x),
        .i_y    (w_y),
        .o_last (w_last),
        .o_acc  (w_acc)
    );

    // Sign restoration of the unsigned core result
    always_comb begin
        w_prod = r_neg_q ? -w_acc : w_acc;
        w_quot = r_neg_q ? -w_acc[WIDTH-1:0] : w_acc[WIDTH-1:0];
        w_rem  = r_neg_r ? -w_acc[2*WIDTH-1:WIDTH] : w_acc[2*WIDTH-1:WIDTH];
    end

    // Control FSM plus HI/LO ownership
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state  <= IDLE;
            r_hi     <= '0;
            r_lo     <= '0;
            r_neg_q  <= 1'b0;
            r_neg_r  <= 1'b0;
            r_is_div <= 1'b0;
            r_dz     <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_muldiv_op) begin
                        r_neg_q  <= w_rs_neg ^ w_rt_neg;
                        r_neg_r  <= w_rs_neg;
                        r_is_div <= w_is_div;
                        r_dz     <= w_is_div && w_rt_zero;
                        r_state  <= w_is_div ? (w_rt_zero ? FIXUP : DIV) : MUL;
                    end else if (w_rtype && ex.funct == FUNCT_MTHI) begin
                        r_hi <= ex.rs_data;
                    end else if (w_rtype && ex.funct == FUNCT_MTLO) begin
                        r_lo <= ex.rs_data;
                    end
                end
                MUL, DIV: begin
                    if (w_last)
                        r_state <= FIXUP;
                end
                FIXUP: begin
                    if (r_dz) begin
                        r_hi <= w_acc[WIDTH-1:0];
                        r_lo <= '1;
                    end else if (r_is_div) begin
                        r_hi <= w_rem;
                        r_lo <= w_quot;
                    end else begin
                        r_hi <= w_prod[2*WIDTH-1:WIDTH];
                        r_lo <= w_prod[WIDTH-1:0];
                    end
                    r_dz    <= 1'b0;
                    r_state <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign ex.stall     = w_load || w_step;
    assign ex.busy      = (r_state != IDLE);
    assign ex.div_zero  = (r_state == FIXUP) && r_dz;
    assign ex.hi        = r_hi;
    assign ex.lo        = r_lo;
    assign ex.mf_valid  = w_rtype && (ex.funct == FUNCT_MFHI || ex.funct == FUNCT_MFLO);
    assign ex.mf_result = !w_rtype             ? '0   :
                          (ex.funct == FUNCT_MFHI) ? r_hi :
                          (ex.funct == FUNCT_MFLO) ? r_lo : '0;
endmodule

// File: tb/tb_ex_muldiv_unit.sv
// Directed plus randomized checks of ex_muldiv_unit against a 64-bit arithmetic model.
module tb_ex_muldiv_unit;
    import mips_pkg::*;

    logic clk;
    logic reset;
    int   checks;
    int   failures;

    ex_muldiv_unit_if #(.WIDTH(32)) bus ();

    ex_muldiv_unit #(.WIDTH(32)) dut (
        .clk   (clk),
        .reset (reset),
        .ex    (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    localparam logic [5:0] NOP = 6'h00;

    // Expected {HI, LO} straight from the arithmetic definition of each instruction
    function automatic logic [63:0] ref_hilo(input logic [5:0] f, input logic [31:0] a,
                                             input logic [31:0] b);
        longint          sa, sb, sq, sr;
        longint unsigned ua, ub, uq, ur;
        logic [63:0]     res;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = {32'h0, a};
        ub = {32'h0, b};
        res = '0;
        case (f)
            FUNCT_MULT:  res = 64'(sa * sb);
            FUNCT_MULTU: res = ua * ub;
            FUNCT_DIV: begin
                if (b == 32'h0) res = {a, 32'hFFFF_FFFF};
                else begin
                    sq = sa / sb;
                    sr = sa % sb;
                    res = {sr[31:0], sq[31:0]};
                end
            end
            FUNCT_DIVU: begin
                if (b == 32'h0) res = {a, 32'hFFFF_FFFF};
                else begin
                    uq = ua / ub;
                    ur = ua % ub;
                    res = {ur[31:0], uq[31:0]};
                end
            end
            default: res = '0;
        endcase
        return res;
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Issue one mul/div op, scramble operands while frozen, then present next_f after FIXUP
    task automatic mdop(input string tag, input logic [5:0] f, input logic [31:0] a,
                        input logic [31:0] b, input logic [5:0] next_f);
        logic [63:0] e;
        bit          dz;
        int          n;
        e  = ref_hilo(f, a, b);
        dz = (f == FUNCT_DIV || f == FUNCT_DIVU) && (b == 32'h0);
        @(negedge clk);
        bus.opcode  = OPCODE_RTYPE;
        bus.funct   = f;
        bus.rs_data = a;
        bus.rt_data = b;
        #1;
        n = 0;
        while (bus.stall && n < 100) begin
            n++;
            @(negedge clk);
            bus.rs_data = $urandom;
            bus.rt_data = $urandom;
        end
        check({tag, "_stall_cycles"}, 64'(n), dz ? 64'd1 : 64'd33);
        check({tag, "_busy_fixup"}, 64'(bus.busy), 64'd1);
        check({tag, "_div_zero"}, 64'(bus.div_zero), 64'(dz));
        bus.funct   = next_f;
        bus.rs_data = $urandom;
        @(negedge clk);
        check({tag, "_busy_after"}, 64'(bus.busy), 64'd0);
        check({tag, "_dz_after"}, 64'(bus.div_zero), 64'd0);
        check({tag, "_hi"}, 64'(bus.hi), 64'(e[63:32]));
        check({tag, "_lo"}, 64'(bus.lo), 64'(e[31:0]));
        if (next_f == FUNCT_MFLO || next_f == FUNCT_MFHI) begin
            check({tag, "_mf_valid"}, 64'(bus.mf_valid), 64'd1);
            check({tag, "_mf_result"}, 64'(bus.mf_result),
                  64'((next_f == FUNCT_MFLO) ? e[31:0] : e[63:32]));
        end
        bus.funct = NOP;
    endtask

    initial begin
        logic [5:0]  f;
        logic [31:0] a;
        logic [31:0] b;
        logic [5:0]  ops [4];
        checks   = 0;
        failures = 0;
        ops[0] = FUNCT_MULT;
        ops[1] = FUNCT_MULTU;
        ops[2] = FUNCT_DIV;
        ops[3] = FUNCT_DIVU;
        reset       = 1'b0;
        bus.opcode  = OPCODE_RTYPE;
        bus.funct   = NOP;
        bus.rs_data = '0;
        bus.rt_data = '0;
        #2 reset = 1'b1;
        repeat (2) @(negedge clk);
        check("rst_stall", 64'(bus.stall), 64'd0);
        check("rst_busy", 64'(bus.busy), 64'd0);
        check("rst_hi", 64'(bus.hi), 64'd0);
        check("rst_lo", 64'(bus.lo), 64'd0);
        check("rst_div_zero", 64'(bus.div_zero), 64'd0);
        check("nop_mf_result", 64'(bus.mf_result), 64'd0);
        reset = 1'b0;

        mdop("multu_max", FUNCT_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, NOP);
        mdop("mult_m3x7", FUNCT_MULT, 32'hFFFF_FFFD, 32'd7, FUNCT_MFLO);
        mdop("div_m7d2", FUNCT_DIV, 32'hFFFF_FFF9, 32'd2, FUNCT_MFHI);
        mdop("div_min_m1", FUNCT_DIV, 32'h8000_0000, 32'hFFFF_FFFF, NOP);
        mdop("divu_by0", FUNCT_DIVU, 32'd100, 32'd0, NOP);
        mdop("div_by0_neg", FUNCT_DIV, 32'hFFFF_FF00, 32'd0, NOP);

        // MTHI then MTLO back-to-back, then MFHI
        @(negedge clk);
        bus.funct = FUNCT_MTHI; bus.rs_data = 32'd5;
        #1 check("mthi_stall", 64'(bus.stall), 64'd0);
        @(negedge clk);
        check("mthi_hi", 64'(bus.hi), 64'd5);
        bus.funct = FUNCT_MTLO; bus.rs_data = 32'd9;
        #1 check("mtlo_stall", 64'(bus.stall), 64'd0);
        @(negedge clk);
        check("mtlo_lo", 64'(bus.lo), 64'd9);
        check("mtlo_hi_kept", 64'(bus.hi), 64'd5);
        bus.funct = FUNCT_MFHI; bus.rs_data = $urandom;
        #1;
        check("mfhi_valid", 64'(bus.mf_valid), 64'd1);
        check("mfhi_result", 64'(bus.mf_result), 64'd5);
        @(negedge clk);
        bus.funct = NOP;

        // Reset in the middle of a DIVU
        @(negedge clk);
        bus.funct = FUNCT_DIVU; bus.rs_data = 32'd1000; bus.rt_data = 32'd7;
        repeat (10) @(negedge clk);
        check("divu_mid_busy", 64'(bus.busy), 64'd1);
        bus.funct = NOP;
        reset = 1'b1;
        #1;
        check("abort_stall", 64'(bus.stall), 64'd0);
        check("abort_busy", 64'(bus.busy), 64'd0);
        check("abort_hi", 64'(bus.hi), 64'd0);
        check("abort_lo", 64'(bus.lo), 64'd0);
        @(negedge clk);
        reset = 1'b0;
        mdop("multu_3x4", FUNCT_MULTU, 32'd3, 32'd4, NOP);

        // Randomized ops, mixing full-range, small and zero divisors and extreme dividends
        for (int k = 0; k < 24; k++) begin
            f = ops[$urandom_range(0, 3)];
            a = $urandom;
            if ($urandom_range(0, 5) == 0) a = 32'h8000_0000;
            case ($urandom_range(0, 3))
                0:       b = 32'h0;
                1:       b = 32'($urandom_range(1, 20));
                2:       b = -32'($urandom_range(1, 20));
                default: b = $urandom;
            endcase
            mdop("rand", f, a, b, ($urandom_range(0, 1) == 1) ? FUNCT_MFLO : FUNCT_MFHI);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
